shift_reg_ctl: RTL and testbench

- Parametrised universal shift register: hold, shift right, shift left and parallel load, with synchronous clear.
- Adds an automatic serializer burst. One start pulse shifts the loaded word out LSB-first over WIDTH cycles with busy/done handshake.
- Sits after the single-bit flip-flop as the team's general storage/serial-conversion element.

---
 rtl/shift_reg_ctl_pkg.sv | 15 +
 rtl/shift_reg_ctl_cell.sv | 39 +++
 rtl/shift_reg_ctl.sv | 150 +++++++++++++++
 tb/tb_shift_reg_ctl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_ctl_pkg.sv
// Shared mode encodings and burst FSM state type for the shift_reg_ctl block.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_reg_ctl_cell.sv
// One storage bit of the universal shift register: 4:1 next-value mux,
// synchronous clear, asynchronous active-low reset.
module shreg_cell
    import shift_reg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic [1:0] sel,
    input  logic       nb_hi,
    input  logic       nb_lo,
    input  logic       ld,
    output logic       q
);

    logic nxt;

    // nb_hi feeds a right shift (towards bit 0), nb_lo feeds a left shift
    always_comb begin
        nxt = q;
        case (sel)
            MODE_HOLD: nxt = q;
            MODE_SHR:  nxt = nb_hi;
            MODE_SHL:  nxt = nb_lo;
            default:   nxt = ld;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/shift_reg_ctl.sv
// Universal shift register with an LSB-first serializer burst (start/busy/done).
// Optional registered parity output when SHREG_PARITY_EN is defined.
//
// state    | meaning
// ST_IDLE  | manual mode active; start launches a burst
// ST_SHIFT | burst running, one right shift per edge, counter counts down
// ST_DONE  | last shift done; next edge drops busy and pulses done
module shift_reg_ctl
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             clr,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
`ifdef SHREG_PARITY_EN
    ,
    output logic             parity
`endif
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_nxt, done_nxt;
    logic [1:0]       sel;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        sel       = MODE_HOLD;
        if (clr) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // start outranks a same-edge load; q is left untouched
                    if (start) begin
                        busy_nxt  = 1'b1;
                        cnt_nxt   = CNT_W'(WIDTH);
                        state_nxt = ST_SHIFT;
                    end else if (en) begin
                        sel = mode;
                    end
                end
                ST_SHIFT: begin
                    sel     = MODE_SHR;
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic nb_hi, nb_lo;
        if (i == WIDTH - 1) begin : g_top
            assign nb_hi = sin_r;
        end else begin : g_mid_hi
            assign nb_hi = q[i+1];
        end
        if (i == 0) begin : g_bot
            assign nb_lo = sin_l;
        end else begin : g_mid_lo
            assign nb_lo = q[i-1];
        end

        shreg_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .sel   (sel),
            .nb_hi (nb_hi),
            .nb_lo (nb_lo),
            .ld    (d[i]),
            .q     (q[i])
        );
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

`ifdef SHREG_PARITY_EN
    logic [WIDTH-1:0] q_nxt;

    // Mirrors the cell muxes so parity lands on the same edge as q
    always_comb begin
        q_nxt = q;
        case (sel)
            MODE_SHR:  q_nxt = {sin_r, q[WIDTH-1:1]};
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_l};
            MODE_LOAD: q_nxt = d;
            default:   q_nxt = q;
        endcase
        if (clr) begin
            q_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity <= 1'b0;
        end else begin
            parity <= ^q_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_shift_reg_ctl.sv
// Directed bench for shift_reg_ctl: manual-mode vector table plus burst,
// abort and async-reset sequences.
module tb_shift_reg_ctl;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic       clr;
    logic       start;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic       busy;
    logic       done;
`ifdef SHREG_PARITY_EN
    logic       parity;
`endif

    int total = 0;
    int bad   = 0;

    shift_reg_ctl #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .clr    (clr),
        .start  (start),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
`ifdef SHREG_PARITY_EN
        ,
        .parity (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sin_r;
        logic       sin_l;
        logic       clr;
        logic [7:0] exp_q;
        logic       exp_sr;
        logic       exp_sl;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; mode = 2'b00; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
        clr = 1'b0; start = 1'b0;
    endtask

    task automatic load(input logic [7:0] val);
        en = 1'b1; mode = 2'b11; d = val;
        tick();
        en = 1'b0; mode = 2'b00;
    endtask

    initial begin
        logic [7:0] burst_word;
        logic [7:0] exp_q;
        int         done_cnt;

        //          en  mode   d      sr    sl    clr   exp_q  sr    sl
        vecs[0]  = '{1'b1, 2'b11, 8'h96, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'hCB, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 2'b11, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1};

        idle_inputs();
        reset = 1'b0;
        #12;
        chk("reset_q", 32'(q), 32'h00);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            en = vecs[i].en; mode = vecs[i].mode; d = vecs[i].d;
            sin_r = vecs[i].sin_r; sin_l = vecs[i].sin_l; clr = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_sout_r", i), 32'(sout_r), 32'(vecs[i].exp_sr));
            chk($sformatf("vec%0d_sout_l", i), 32'(sout_l), 32'(vecs[i].exp_sl));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end
        idle_inputs();

        // async reset between edges with q=A5
        #3 reset = 1'b0;
        #1;
        chk("async_rst_q", 32'(q), 32'h00);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_done", 32'(done), 32'h0);
        #1 reset = 1'b1;
        tick();

        // burst of 3C; start coincides with a load of FF, which must lose
        burst_word = 8'h3C;
        load(burst_word);
        start = 1'b1; en = 1'b1; mode = 2'b11; d = 8'hFF; sin_r = 1'b0;
        done_cnt = 0;
        for (int e = 0; e <= 10; e++) begin
            tick();
            start = 1'b0; en = 1'b0; mode = 2'b00; sin_l = 1'b1;
            exp_q = (e < 8) ? (burst_word >> e) : 8'h00;
            chk($sformatf("burst_e%0d_q", e), 32'(q), 32'(exp_q));
            chk($sformatf("burst_e%0d_busy", e), 32'(busy), 32'(e <= 8));
            chk($sformatf("burst_e%0d_done", e), 32'(done), 32'(e == 9));
            if (e < 8) begin
                chk($sformatf("burst_e%0d_sout_r", e), 32'(sout_r), 32'(burst_word[e]));
            end
            if (done) done_cnt++;
            if (e == 2) begin
                start = 1'b1; en = 1'b1; mode = 2'b11; d = 8'hFF;
            end
        end
        chk("burst_done_count", 32'(done_cnt), 32'd1);
        idle_inputs();

        // manual mode works again after the burst
        load(8'h5A);
        chk("post_burst_load", 32'(q), 32'h5A);

        // abort with clr on the 4th shift
        load(8'h3C);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_q", 32'(q), 32'h07);
        chk("abort_pre_busy", 32'(busy), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("abort_q", 32'(q), 32'h00);
        chk("abort_busy", 32'(busy), 32'h0);
        done_cnt = 0;
        for (int e = 0; e < 12; e++) begin
            if (done) done_cnt++;
            if (busy) done_cnt += 100;
            tick();
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        load(8'hC3);
        chk("abort_idle_load", 32'(q), 32'hC3);

        // async reset in the middle of a burst
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("midburst_busy", 32'(busy), 32'h1);
        #3 reset = 1'b0;
        #1;
        chk("midburst_rst_q", 32'(q), 32'h00);
        chk("midburst_rst_busy", 32'(busy), 32'h0);
        #1 reset = 1'b1;
        tick(); tick();
        chk("after_rst_busy", 32'(busy), 32'h0);
        chk("after_rst_done", 32'(done), 32'h0);

`ifdef SHREG_PARITY_EN
        load(8'h07);
        chk("par_07_q", 32'(q), 32'h07);
        chk("par_07", 32'(parity), 32'h1);
        load(8'h03);
        chk("par_03", 32'(parity), 32'h0);
        load(8'h0B);
        chk("par_0B", 32'(parity), 32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("par_clr", 32'(parity), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
